// File: rtl/mult8_seq_sched_pkg.sv
// Shared types and step tables for the sequential 8x8 multiplier.
package mult8_seq_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int STEP_W = 2;
  localparam int NSTEPS = 4;

  // Nibble select per step: {a_hi, b_hi}.
  localparam logic [1:0] NIB_SEL [NSTEPS] = '{2'b00, 2'b01, 2'b10, 2'b11};

  // Shift per step, in units of SUBW: {0, SUBW, SUBW, 2*SUBW}.
  localparam int unsigned SHIFT_MUL [NSTEPS] = '{0, 1, 1, 2};

  // Left-shift applied to the partial product of a given step.
  function automatic int unsigned step_shift(input logic [STEP_W-1:0] step,
                                             input int unsigned subw);
    return SHIFT_MUL[step] * subw;
  endfunction

endpackage

// File: rtl/mult8_seq_sched_if.sv
// Operand/result handshake bundle between producer/consumer and multiplier.
interface mult8_seq_sched_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] P;
  logic           busy;

  // Master drives operands and consumes the product.
  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, P, busy
  );

  // Slave is the multiplier itself.
  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, P, busy
  );
endinterface

// File: rtl/mult8_seq_sched_mult_sub_comb.sv
// Purely combinational SUBW x SUBW unsigned multiplier; any generated
// multiplier with the same A/B/P shape can be dropped in instead.
module mult_sub_comb #(
  parameter int SUBW = 4
) (
  input  logic [SUBW-1:0]   A,
  input  logic [SUBW-1:0]   B,
  output logic [2*SUBW-1:0] P
);
  // Zero-extend before multiplying so the full product is kept.
  assign P = {{SUBW{1'b0}}, A} * {{SUBW{1'b0}}, B};
endmodule

// File: rtl/mult8_seq_sched.sv
// Sequential WxW unsigned multiplier: one shared SUBW x SUBW multiplier
// walks the four nibble partial products and accumulates them.
// W must equal 2*SUBW.
module mult8_seq_sched
  import mult8_seq_sched_pkg::*;
#(
  parameter int W    = 8,
  parameter int SUBW = 4
) (
  input  logic            clk,
  input  logic            rst,
  mult8_seq_sched_if.slave bus
);

  localparam int SHAMT_W = $clog2(2*W);

  state_t              r_state, w_next;
  logic [STEP_W-1:0]   r_step;
  logic [W-1:0]        r_a, r_b;
  logic [2*W-1:0]      r_acc;

  logic                w_in_ready, w_out_valid, w_busy;
  logic                w_accept;
  logic [1:0]          w_sel;
  logic [SUBW-1:0]     w_a_nib, w_b_nib;
  logic [2*SUBW-1:0]   w_pp;
  logic [2*W-1:0]      w_pp_sh;
  logic [SHAMT_W-1:0]  w_shamt;

  assign w_accept = bus.in_valid & w_in_ready;

  // Step-driven nibble selection and shift amount.
  assign w_sel   = NIB_SEL[r_step];
  assign w_a_nib = w_sel[1] ? r_a[W-1:SUBW] : r_a[SUBW-1:0];
  assign w_b_nib = w_sel[0] ? r_b[W-1:SUBW] : r_b[SUBW-1:0];
  assign w_shamt = SHAMT_W'(step_shift(r_step, SUBW));

  mult_sub_comb #(.SUBW(SUBW)) u_sub (
    .A (w_a_nib),
    .B (w_b_nib),
    .P (w_pp)
  );

  assign w_pp_sh = {{(2*W-2*SUBW){1'b0}}, w_pp} << w_shamt;

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid) w_next = ST_CALC;
      ST_CALC: if (r_step == STEP_W'(NSTEPS-1)) w_next = ST_DONE;
      ST_DONE: if (bus.out_ready) w_next = bus.in_valid ? ST_CALC : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Handshake outputs; in_ready in DONE follows out_ready so a new
  // operand pair can be taken on the same edge the result leaves.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      ST_IDLE: w_in_ready = 1'b1;
      ST_CALC: w_busy     = 1'b1;
      ST_DONE: begin
        w_out_valid = 1'b1;
        w_busy      = 1'b1;
        w_in_ready  = bus.out_ready;
      end
      default: ;
    endcase
  end

  // Operand latch, step counter and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step <= '0;
      r_acc  <= '0;
      r_a    <= '0;
      r_b    <= '0;
    end else if (w_accept) begin
      r_a    <= bus.A;
      r_b    <= bus.B;
      r_acc  <= '0;
      r_step <= '0;
    end else if (r_state == ST_CALC) begin
      r_acc  <= r_acc + w_pp_sh;
      r_step <= r_step + 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.P         = r_acc;

endmodule
